stage_fifo: RTL and testbench
=============================

STAGE_FIFO -- requirements
Module: stage_fifo

Interface
REQ-001 Parameter WIDTH, default 8: opcode width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of two and >= 2.
REQ-003 Parameter DROP_NOP, default 1: when 1, an all-zero opcode (NOP) offered upstream SHALL be consumed but not stored.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all buffered operations.
REQ-007 operation_in  input  WIDTH  opcode offered by the upstream stage.
REQ-008 ack  output  1  high = this stage accepts operation_in this cycle.
REQ-009 operation  output  WIDTH  head-of-buffer opcode presented to the downstream stage; 0 when empty.
REQ-010 ack_in  input  1  high = downstream consumes operation this cycle.
REQ-011 count  output  $clog2(DEPTH+1)  number of buffered entries.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.

Function
REQ-014 ack SHALL equal !full and SHALL be a function of registered state only, with no combinational path from ack_in or operation_in.
REQ-015 operation SHALL be driven from storage/registers only, with no combinational path from operation_in.
REQ-016 Accept event: ack high; operation_in is then taken regardless of its value.
REQ-017 Push event: accept AND (DROP_NOP == 0 OR operation_in != 0); a push writes operation_in at the write pointer.
REQ-018 Pop event: ack_in high AND empty low; a pop advances the read pointer.
REQ-019 ack_in while empty SHALL be ignored: no pointer or count change.
REQ-020 Push without pop: count +1. Pop without push: count -1. Push and pop in the same cycle: count unchanged, both pointers advance.
REQ-021 When full, ack is 0, so no push occurs even if a pop happens that cycle; the freed slot becomes acceptable the next cycle.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-023 Latency: an opcode pushed into an empty buffer at edge N SHALL appear on operation after edge N, i.e. one cycle after acceptance.
REQ-024 Ordering SHALL be strict FIFO; no stored entry is ever dropped or duplicated.
REQ-025 flush high at an edge: count, read pointer and write pointer SHALL go to 0, and operation SHALL read 0 from the next cycle.
REQ-026 flush SHALL take priority over push and pop in the same cycle; both are discarded.
REQ-027 ack stays !full during a flush cycle; an opcode accepted during that cycle is lost, which is intended flush semantics.
REQ-028 full and empty SHALL be derived from count, and both SHALL never be high together.

Reset
REQ-029 reset low SHALL immediately, without waiting for a clock edge, force count=0, pointers=0, operation=0, empty=1, full=0, ack=1.
REQ-030 Storage array contents are don't-care after reset; no output SHALL expose them while empty.
REQ-031 Reset asserted mid-operation SHALL discard all entries, and it SHALL override flush, push and pop.
REQ-032 After reset deasserts, the first rising edge SHALL behave as a normal cycle.

Verification
REQ-033 DEPTH=4, DROP_NOP=1, ack_in=0: push 0x11, 0x22, 0x33, 0x44 -> full=1, ack=0, count=4, operation=0x11; a fifth offered value (0x55) is not accepted.
REQ-034 From that full state, ack_in=1 for 4 cycles -> operation sequence 0x11, 0x22, 0x33, 0x44, then 0; empty=1 and ack=1 after the 4th pop.
REQ-035 count=2, with a simultaneous push (0x66) and pop every cycle for 6 cycles -> count stays 2, the order is preserved across pointer wrap, and no gaps appear on operation.
REQ-036 DROP_NOP=1, offer 0x00 then 0x07 with ack_in=0 -> count=1 and operation=0x07. Same stimulus with DROP_NOP=0 -> count=2 and operation=0x00 first.
REQ-037 count=3 with flush=1, push 0x99 and ack_in=1 on the same edge -> next cycle count=0, operation=0, empty=1; 0x99 never appears.
REQ-038 reset pulsed low between clock edges while count=3 -> outputs reach reset values before the next edge; the first push after release appears after one cycle.

Source files
------------

// File: rtl/stage_fifo.sv
// Elastic stage buffer between two pipeline stages. Upstream hands off opcodes
// on ack, and downstream pulls the head entry with ack_in. Optionally drops NOPs.
module stage_fifo #(
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 4,
   parameter  int DROP_NOP = 1,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] operation_in,
   output logic             ack,
   output logic [WIDTH-1:0] operation,
   input  logic             ack_in,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic accept;
   logic push;
   logic pop;

   // Handshake outputs depend on the registered count only.
   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign ack    = ~full;
   assign count  = count_q;

   assign accept = ack;
   assign push   = accept && ((DROP_NOP == 0) || (operation_in != '0));
   assign pop    = ack_in && !empty;

   // Masking with empty keeps stale or uninitialised storage off the output.
   assign operation = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage has no reset; its contents only become visible once count covers them.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= operation_in;
      end
   end

endmodule

// File: tb/tb_stage_fifo.sv
// Bench for stage_fifo. It drives one stimulus into two instances, one that drops
// NOPs and one that keeps them, and compares each against a queue-based model.
module tb_stage_fifo;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = 3;

   typedef logic [W-1:0] q_t [$];

   logic          clk;
   logic          reset;
   logic          flush;
   logic          ack_in;
   logic [W-1:0]  op_in;

   logic          ack_a, full_a, empty_a;
   logic [W-1:0]  op_a;
   logic [CW-1:0] cnt_a;
   logic          ack_b, full_b, empty_b;
   logic [W-1:0]  op_b;
   logic [CW-1:0] cnt_b;

   q_t qa, qb;
   int compared   = 0;
   int mismatched = 0;

   logic          r_fl, r_ai;
   logic [W-1:0]  r_op;
   logic [W-1:0]  pop_exp [4];

   stage_fifo #(.WIDTH(W), .DEPTH(D), .DROP_NOP(1)) u_drop (
      .clk(clk), .reset(reset), .flush(flush), .operation_in(op_in),
      .ack(ack_a), .operation(op_a), .ack_in(ack_in),
      .count(cnt_a), .full(full_a), .empty(empty_a)
   );

   stage_fifo #(.WIDTH(W), .DEPTH(D), .DROP_NOP(0)) u_keep (
      .clk(clk), .reset(reset), .flush(flush), .operation_in(op_in),
      .ack(ack_b), .operation(op_b), .ack_in(ack_in),
      .count(cnt_b), .full(full_b), .empty(empty_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference behaviour for one clock edge: flush clears, otherwise pop the head
   // and append the offered opcode if there was room at the start of the cycle.
   function automatic q_t model_step(q_t q, bit drop, bit fl, bit ai, logic [W-1:0] oi);
      q_t r;
      bit room;
      bit take;
      bit give;
      r    = q;
      room = (r.size() < D);
      take = room && (!drop || (oi != '0));
      give = ai && (r.size() > 0);
      if (fl) begin
         r.delete();
      end else begin
         if (give) void'(r.pop_front());
         if (take) r.push_back(oi);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a_count", 32'(cnt_a), 32'(qa.size()));
      chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
      chk("a_full",  32'(full_a), 32'(qa.size() == D));
      chk("a_ack",   32'(ack_a), 32'(qa.size() < D));
      chk("a_op",    32'(op_a), 32'((qa.size() > 0) ? qa[0] : 8'h00));
      chk("b_count", 32'(cnt_b), 32'(qb.size()));
      chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
      chk("b_full",  32'(full_b), 32'(qb.size() == D));
      chk("b_ack",   32'(ack_b), 32'(qb.size() < D));
      chk("b_op",    32'(op_b), 32'((qb.size() > 0) ? qb[0] : 8'h00));
   endtask

   // Let one edge pass with the inputs as they stand.
   task automatic idle_edge();
      @(posedge clk);
      qa = model_step(qa, 1'b1, flush, ack_in, op_in);
      qb = model_step(qb, 1'b0, flush, ack_in, op_in);
      #1 check_all();
   endtask

   task automatic cyc(input logic fl, input logic ai, input logic [W-1:0] oi);
      @(negedge clk);
      flush  = fl;
      ack_in = ai;
      op_in  = oi;
      @(posedge clk);
      qa = model_step(qa, 1'b1, fl, ai, oi);
      qb = model_step(qb, 1'b0, fl, ai, oi);
      #1 check_all();
   endtask

   initial begin
      reset  = 1'b0;
      flush  = 1'b1;
      ack_in = 1'b0;
      op_in  = 8'h00;
      #1;
      check_all();
      chk("rst_ack", 32'(ack_a), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      idle_edge();

      // Fill to full, then offer one more.
      cyc(1'b0, 1'b0, 8'h11);
      chk("fill_first_latency", 32'(op_a), 32'h11);
      cyc(1'b0, 1'b0, 8'h22);
      cyc(1'b0, 1'b0, 8'h33);
      cyc(1'b0, 1'b0, 8'h44);
      chk("full_count", 32'(cnt_a), 32'd4);
      chk("full_flag", 32'(full_a), 32'd1);
      chk("full_ack", 32'(ack_a), 32'd0);
      chk("full_head", 32'(op_a), 32'h11);
      cyc(1'b0, 1'b0, 8'h55);
      chk("fifth_rejected", 32'(cnt_a), 32'd4);

      // Drain.
      pop_exp[0] = 8'h22;
      pop_exp[1] = 8'h33;
      pop_exp[2] = 8'h44;
      pop_exp[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         chk("drain_seq", 32'(op_a), 32'(pop_exp[i]));
      end
      chk("drain_empty", 32'(empty_a), 32'd1);
      chk("drain_ack", 32'(ack_a), 32'd1);
      cyc(1'b1, 1'b0, 8'h00);

      // Steady push+pop across pointer wrap.
      cyc(1'b0, 1'b0, 8'h01);
      cyc(1'b0, 1'b0, 8'h02);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, 8'h66);
         chk("stream_count", 32'(cnt_a), 32'd2);
      end
      cyc(1'b1, 1'b0, 8'h00);

      // NOP handling differs between the two instances.
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h07);
      chk("nop_drop_count", 32'(cnt_a), 32'd1);
      chk("nop_drop_head", 32'(op_a), 32'h07);
      chk("nop_keep_count", 32'(cnt_b), 32'd2);
      chk("nop_keep_head", 32'(op_b), 32'h00);
      cyc(1'b1, 1'b0, 8'h00);

      // Flush beats a simultaneous push and pop.
      cyc(1'b0, 1'b0, 8'h01);
      cyc(1'b0, 1'b0, 8'h02);
      cyc(1'b0, 1'b0, 8'h03);
      cyc(1'b1, 1'b1, 8'h99);
      chk("flush_count", 32'(cnt_a), 32'd0);
      chk("flush_op", 32'(op_a), 32'd0);
      chk("flush_empty", 32'(empty_a), 32'd1);
      cyc(1'b0, 1'b1, 8'h00);

      // Asynchronous reset between edges while holding three entries.
      cyc(1'b0, 1'b0, 8'h0A);
      cyc(1'b0, 1'b0, 8'h0B);
      cyc(1'b0, 1'b0, 8'h0C);
      @(negedge clk);
      flush  = 1'b1;
      ack_in = 1'b0;
      op_in  = 8'h00;
      #2 reset = 1'b0;
      qa.delete();
      qb.delete();
      #1;
      check_all();
      chk("async_rst_count", 32'(cnt_a), 32'd0);
      chk("async_rst_op", 32'(op_a), 32'd0);
      #1 reset = 1'b1;
      idle_edge();
      cyc(1'b0, 1'b0, 8'h5A);
      chk("post_rst_push", 32'(op_a), 32'h5A);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         r_fl = ($urandom_range(0, 19) == 0);
         r_ai = 1'($urandom_range(0, 1));
         r_op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         cyc(r_fl, r_ai, r_op);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
